ysyx_22040759_lsu_stage: RTL and testbench
==========================================

// Module: ysyx_22040759_lsu_stage
// PURPOSE
//  Parametrised MEM/LSU pipeline stage between EX and WB.
//  Per-instruction FSM holds a valid/ready request to the dcache until handshake.
//  Builds byte-lane write data and strobes for stores; sign/zero-extends loads.
//  Gives WB a single result and feeds forward/hazard units.
// PARAMETERS
//  XLEN    64  datapath width, 32 or 64; bus bytes NB=XLEN/8, OFS=log2(NB)
//  ADDR_W  32  memory address width, <= XLEN
//  RD_W    5   destination register index width
// PORTS
//  clk            in   1        clock
//  rst            in   1        sync active-high reset
//  es_to_ms_valid in   1        EX holds a valid instruction
//  ms_allowin     out  1        stage can accept from EX this cycle
//  es_pc          in   XLEN     instruction PC
//  es_alu_result  in   XLEN     ALU result / effective address
//  es_src2        in   XLEN     store data
//  es_mem_ren     in   1        load
//  es_mem_wen     in   1        store (ren&wen never both 1)
//  es_func3       in   3        RISC-V load/store funct3
//  es_rd          in   RD_W     destination register
//  es_reg_wen     in   1        writes register
//  ws_allowin     in   1        WB can accept
//  ms_to_ws_valid out  1        result valid to WB
//  ms_pc          out  XLEN     latched PC
//  ms_rd          out  RD_W     latched rd
//  ms_reg_wen     out  1        latched reg_wen (0 on excp when MISALIGN_CHECK_EN)
//  ms_result      out  XLEN     extended load data, else ALU result
//  ms_isload      out  1        valid load in stage not yet done (hazard stall)
//  mem_valid      out  1        dcache request
//  mem_ready      in   1        dcache accepts/completes; rdata valid same cycle
//  mem_wen        out  1        1 store, 0 load
//  mem_addr       out  ADDR_W   byte address, low ADDR_W bits of alu result
//  mem_size       out  2        log2 access bytes (0..3)
//  mem_wdata      out  XLEN     store data shifted to lane addr[OFS-1:0]
//  mem_wstrb      out  NB       byte strobes, ((1<<bytes)-1)<<addr[OFS-1:0]
//  mem_rdata      in   XLEN     aligned bus word read
// BEHAVIOUR
//  Reset: ms_valid=0, state=IDLE, mem_valid=0, ms_to_ws_valid=0, ms_isload=0; datapath regs don't-care.
//  Accept: es_to_ms_valid & ms_allowin latches all es_* into stage regs.
//  ms_allowin = !ms_valid | (ready_go & ws_allowin).
//  FSM:
//   IDLE: non-mem instr -> ready_go=1 same cycle (0 extra latency).
//   IDLE: mem instr -> REQ next cycle.
//   REQ: mem_valid=1, addr/size/wdata/wstrb stable.
//   REQ: mem_valid&mem_ready -> capture extended rdata, -> DONE.
//   DONE: ready_go=1; if ws_allowin: no new mem instr accepted -> IDLE, else -> REQ.
//  mem_valid never drops in REQ before handshake, except rst.
//  Load latency: >= 2 cycles after accept (REQ + DONE); each mem_ready stall adds one.
//  Load extract: shift mem_rdata right by 8*addr[OFS-1:0].
//   funct3 000/001/010/011 sign-extend b/h/w/d; 100/101/110 zero-extend b/h/w.
//   XLEN=32: 011 and 110 act as 010.
//  Store funct3 000/001/010/011 -> mem_size 0/1/2/3; store data replicated into lanes.
//  Stores write ms_result = alu result; reg_wen passes through unchanged (normally 0).
//  Back-pressure: DONE with ws_allowin=0 holds result and state, no new request.
//  ms_isload=1 from accept of a load until DONE.
//  rst mid-REQ: request abandoned, mem_valid=0 next cycle; dcache tolerates drop under reset.
// CONFIGURATION
//  MISALIGN_CHECK_EN defined:
//   - addr not aligned to size -> no mem request; go straight to DONE.
//   - assert output ms_excp (1 bit, reset 0) with ms_reg_wen forced 0.
//  MISALIGN_CHECK_EN undefined:
//   - no ms_excp port; misaligned access issued as-is.
//   - lanes past NB truncated, strobes masked to NB bits.
// TESTING
//  ALU instr rd=5, ws_allowin=1 -> ms_to_ws_valid 1 cycle after accept, ms_result=alu.
//  lb addr 0x80000003, rdata 0x00000000_80FF0000, mem_ready 1st REQ cycle -> ms_result=0xFFFFFFFF_FFFFFF80.
//  lhu addr 0x80000006, mem_ready delayed 3 cycles -> mem_valid held 4 cycles, ms_result=0x8000 for rdata 0x8000_0000_0000_0000.
//  sb addr 0x80000005 data 0xAB -> mem_wstrb=0x20, mem_wdata[47:40]=0xAB, mem_wen=1.
//  Back-to-back loads, ws_allowin=0 two cycles in DONE -> result held, second load waits, DONE->REQ direct.
//  rst in REQ -> mem_valid=0 and ms_to_ws_valid=0 next cycle; MISALIGN_CHECK_EN lw at 0x2 -> ms_excp=1, no mem_valid.

Source files
------------

// File: rtl/ysyx_22040759_lsu_stage.sv
`timescale 1ns/1ps
// MEM/LSU pipeline stage: holds one instruction, issues dcache requests, builds store lanes, extends loads.
// Optional MISALIGN_CHECK_EN: misaligned accesses raise ms_excp instead of reaching the dcache.
module ysyx_22040759_lsu_stage #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 32,
    parameter int RD_W   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                es_to_ms_valid,
    output logic                ms_allowin,
    input  logic [XLEN-1:0]     es_pc,
    input  logic [XLEN-1:0]     es_alu_result,
    input  logic [XLEN-1:0]     es_src2,
    input  logic                es_mem_ren,
    input  logic                es_mem_wen,
    input  logic [2:0]          es_func3,
    input  logic [RD_W-1:0]     es_rd,
    input  logic                es_reg_wen,
    input  logic                ws_allowin,
    output logic                ms_to_ws_valid,
    output logic [XLEN-1:0]     ms_pc,
    output logic [RD_W-1:0]     ms_rd,
    output logic                ms_reg_wen,
    output logic [XLEN-1:0]     ms_result,
    output logic                ms_isload,
`ifdef MISALIGN_CHECK_EN
    output logic                ms_excp,
`endif
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [1:0]          mem_size,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wstrb,
    input  logic [XLEN-1:0]     mem_rdata
);
    localparam int NB  = XLEN / 8;
    localparam int OFS = $clog2(NB);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t             state_reg, state_next;
    logic               ms_valid_reg, ms_valid_next;
    logic               excp_reg;
    logic [XLEN-1:0]    pc_reg, alu_reg, src2_reg, ld_data_reg;
    logic               ren_reg, wen_reg, reg_wen_reg;
    logic [2:0]         func3_reg;
    logic [RD_W-1:0]    rd_reg;

    logic               accept, ready_go, es_is_mem, es_misalign;
    logic [OFS-1:0]     ofs;
    logic [NB-1:0]      strb_base;
    logic [XLEN-1:0]    rd_shift, ld_mask, ld_ext;
    logic [1:0]         ld_size;
    logic               ld_msb;

    assign es_is_mem      = es_mem_ren | es_mem_wen;
    assign ready_go       = (state_reg != S_REQ);
    assign ms_to_ws_valid = ms_valid_reg & ready_go;
    assign ms_allowin     = !ms_valid_reg | (ready_go & ws_allowin);
    assign accept         = es_to_ms_valid & ms_allowin;

`ifdef MISALIGN_CHECK_EN
    always_comb begin
        es_misalign = 1'b0;
        if (es_is_mem) begin
            case (es_func3[1:0])
                2'd1:    es_misalign = es_alu_result[0];
                2'd2:    es_misalign = |es_alu_result[1:0];
                2'd3:    es_misalign = |es_alu_result[2:0];
                default: es_misalign = 1'b0;
            endcase
        end
    end
    assign ms_excp = ms_valid_reg & excp_reg;
`else
    assign es_misalign = 1'b0;
`endif

    // A new memory instruction may be accepted straight out of DONE, going to REQ without an IDLE bubble.
    always_comb begin
        state_next    = state_reg;
        ms_valid_next = ms_valid_reg;
        if (ms_to_ws_valid && ws_allowin) begin
            ms_valid_next = 1'b0;
        end
        if (accept) begin
            ms_valid_next = 1'b1;
            if (es_is_mem) begin
                state_next = es_misalign ? S_DONE : S_REQ;
            end else begin
                state_next = S_IDLE;
            end
        end else begin
            case (state_reg)
                S_REQ:   if (mem_ready) state_next = S_DONE;
                S_DONE:  if (ws_allowin) state_next = S_IDLE;
                default: state_next = state_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            ms_valid_reg <= 1'b0;
            excp_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ms_valid_reg <= ms_valid_next;
            if (accept) begin
                excp_reg <= es_misalign;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pc_reg      <= es_pc;
            alu_reg     <= es_alu_result;
            src2_reg    <= es_src2;
            ren_reg     <= es_mem_ren;
            wen_reg     <= es_mem_wen;
            func3_reg   <= es_func3;
            rd_reg      <= es_rd;
            reg_wen_reg <= es_reg_wen;
        end
        if (state_reg == S_REQ && mem_ready) begin
            ld_data_reg <= ld_ext;
        end
    end

    assign ofs       = alu_reg[OFS-1:0];
    assign mem_valid = (state_reg == S_REQ);
    assign mem_wen   = wen_reg;
    assign mem_addr  = alu_reg[ADDR_W-1:0];
    assign mem_size  = func3_reg[1:0];
    // Lanes shifted past the top of the bus word simply fall off.
    assign mem_wdata = src2_reg << {ofs, 3'b000};

    always_comb begin
        case (func3_reg[1:0])
            2'd0:    strb_base = NB'(1);
            2'd1:    strb_base = NB'(3);
            2'd2:    strb_base = NB'(15);
            default: strb_base = '1;
        endcase
    end
    assign mem_wstrb = strb_base << ofs;

    // Doubleword loads degrade to word loads on a 32-bit datapath.
    assign rd_shift = mem_rdata >> {ofs, 3'b000};
    assign ld_size  = (XLEN == 32 && func3_reg[1:0] == 2'd3) ? 2'd2 : func3_reg[1:0];

    always_comb begin
        ld_mask = '1;
        ld_msb  = rd_shift[XLEN-1];
        case (ld_size)
            2'd0:    begin ld_mask = XLEN'(8'hFF);         ld_msb = rd_shift[7];  end
            2'd1:    begin ld_mask = XLEN'(16'hFFFF);      ld_msb = rd_shift[15]; end
            2'd2:    begin ld_mask = XLEN'(32'hFFFF_FFFF); ld_msb = rd_shift[31]; end
            default: begin ld_mask = '1;                   ld_msb = rd_shift[XLEN-1]; end
        endcase
        ld_ext = (rd_shift & ld_mask) | ((!func3_reg[2] && ld_msb) ? ~ld_mask : '0);
    end

    assign ms_pc      = pc_reg;
    assign ms_rd      = rd_reg;
    assign ms_reg_wen = reg_wen_reg & ~excp_reg;
    assign ms_result  = (ren_reg && !excp_reg) ? ld_data_reg : alu_reg;
    assign ms_isload  = ms_valid_reg & ren_reg & (state_reg != S_DONE);

endmodule

// File: tb/tb_ysyx_22040759_lsu_stage.sv
`timescale 1ns/1ps
// Bench for the LSU stage: directed scenarios, then random EX/dcache/WB traffic against a byte-level model.
module tb_ysyx_22040759_lsu_stage;
    localparam int XLEN   = 64;
    localparam int ADDR_W = 32;
    localparam int RD_W   = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              es_to_ms_valid, ms_allowin;
    logic [XLEN-1:0]   es_pc, es_alu_result, es_src2;
    logic              es_mem_ren, es_mem_wen, es_reg_wen;
    logic [2:0]        es_func3;
    logic [RD_W-1:0]   es_rd;
    logic              ws_allowin, ms_to_ws_valid;
    logic [XLEN-1:0]   ms_pc, ms_result;
    logic [RD_W-1:0]   ms_rd;
    logic              ms_reg_wen, ms_isload;
`ifdef MISALIGN_CHECK_EN
    logic              ms_excp;
`endif
    logic              mem_valid, mem_ready, mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_size;
    logic [XLEN-1:0]   mem_wdata, mem_rdata;
    logic [7:0]        mem_wstrb;

    ysyx_22040759_lsu_stage #(.XLEN(XLEN), .ADDR_W(ADDR_W), .RD_W(RD_W)) dut (
        .clk(clk), .rst(rst),
        .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .es_pc(es_pc), .es_alu_result(es_alu_result), .es_src2(es_src2),
        .es_mem_ren(es_mem_ren), .es_mem_wen(es_mem_wen), .es_func3(es_func3),
        .es_rd(es_rd), .es_reg_wen(es_reg_wen), .ws_allowin(ws_allowin),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc), .ms_rd(ms_rd),
        .ms_reg_wen(ms_reg_wen), .ms_result(ms_result), .ms_isload(ms_isload),
`ifdef MISALIGN_CHECK_EN
        .ms_excp(ms_excp),
`endif
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_size(mem_size), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] alu;
        logic [63:0] src2;
        logic        ren;
        logic        wen;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        reg_wen;
    } instr_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Deterministic memory contents: every aligned doubleword is a function of its address.
    function automatic logic [63:0] mem_word(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:3], 3'b000};
        return {b ^ 32'hC3A5_0F1E, b * 32'h9E37_79B1};
    endfunction

    function automatic logic [63:0] load_ref(input logic [31:0] a, input logic [2:0] f3, input logic [63:0] word);
        int          nbytes;
        logic [63:0] v, r, sgn;
        nbytes = 1 << f3[1:0];
        v = word >> (8 * a[2:0]);
        r = '0;
        for (int i = 0; i < nbytes * 8; i++) r[i] = v[i];
        sgn = (v >> (nbytes * 8 - 1)) & 64'd1;
        if (!f3[2] && nbytes < 8 && sgn[0])
            for (int i = nbytes * 8; i < 64; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [7:0] strb_ref(input logic [2:0] f3, input logic [2:0] off);
        int         nbytes;
        logic [7:0] s;
        nbytes = 1 << f3[1:0];
        s = '0;
        for (int i = 0; i < 8; i++) if (i >= int'(off) && i < int'(off) + nbytes) s[i] = 1'b1;
        return s;
    endfunction

    function automatic instr_t gen_instr();
        instr_t      t;
        int          kind;
        logic [31:0] a;
        kind = $urandom_range(0, 2);
        a = 32'h8000_0000 | 32'($urandom_range(0, 255));
        t.pc   = {32'h0, $urandom};
        t.src2 = {$urandom, $urandom};
        t.ren  = (kind == 1);
        t.wen  = (kind == 2);
        t.f3   = (kind == 1) ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 3));
`ifdef MISALIGN_CHECK_EN
        if (kind != 0) a = a & ~((32'd1 << t.f3[1:0]) - 32'd1);
`endif
        t.alu     = (kind == 0) ? {$urandom, $urandom} : {$urandom, a};
        t.rd      = 5'($urandom);
        t.reg_wen = (kind == 2) ? 1'($urandom) : 1'b1;
        return t;
    endfunction

    task automatic drive(input instr_t t, input logic v);
        es_to_ms_valid = v;
        es_pc = t.pc; es_alu_result = t.alu; es_src2 = t.src2;
        es_mem_ren = t.ren; es_mem_wen = t.wen; es_func3 = t.f3;
        es_rd = t.rd; es_reg_wen = t.reg_wen;
    endtask

    instr_t t0, t1, cur, ex_q;
    bit     in_stage, done, ex_has, exp_to_ws;
    int     retired;
    logic [7:0]  es;
    logic [63:0] got_l, exp_l, tmp, exp_res;

    initial begin
        rst = 1'b1; mem_ready = 1'b0; mem_rdata = '0; ws_allowin = 1'b1;
        t0 = '0; drive(t0, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_to_ws", ms_to_ws_valid, 0);
        check("rst_isload", ms_isload, 0);
        rst = 1'b0;

        // ALU instruction: result one cycle after accept
        @(negedge clk);
        t0 = '0; t0.pc = 64'h100; t0.alu = 64'h1234_5678_9ABC_DEF0; t0.rd = 5'd5; t0.reg_wen = 1'b1;
        drive(t0, 1'b1); #1;
        check("alu_allowin", ms_allowin, 1);
        @(negedge clk); es_to_ms_valid = 1'b0;
        check("alu_to_ws", ms_to_ws_valid, 1);
        check("alu_result", ms_result, 64'h1234_5678_9ABC_DEF0);
        check("alu_rd", ms_rd, 5);
        check("alu_mem_valid", mem_valid, 0);
        $display("[TB] alu pc=%h result=%h", ms_pc, ms_result);
        @(negedge clk);
        check("alu_drained", ms_to_ws_valid, 0);

        // lb with immediate ready
        t0 = '0; t0.pc = 64'h104; t0.alu = 64'h8000_0003; t0.ren = 1'b1; t0.f3 = 3'b000; t0.rd = 5'd6; t0.reg_wen = 1'b1;
        drive(t0, 1'b1);
        @(negedge clk); es_to_ms_valid = 1'b0;
        check("lb_mem_valid", mem_valid, 1);
        check("lb_isload", ms_isload, 1);
        check("lb_addr", mem_addr, 32'h8000_0003);
        check("lb_wen", mem_wen, 0);
        mem_rdata = 64'h0000_0000_80FF_0000; mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        check("lb_to_ws", ms_to_ws_valid, 1);
        check("lb_isload_done", ms_isload, 0);
        check("lb_result", ms_result, 64'hFFFF_FFFF_FFFF_FF80);
        $display("[TB] lb pc=%h result=%h", ms_pc, ms_result);
        @(negedge clk);

        // lhu with a three-cycle dcache stall
        t0 = '0; t0.pc = 64'h108; t0.alu = 64'h8000_0006; t0.ren = 1'b1; t0.f3 = 3'b101; t0.rd = 5'd7; t0.reg_wen = 1'b1;
        drive(t0, 1'b1);
        @(negedge clk); es_to_ms_valid = 1'b0;
        mem_rdata = 64'h8000_0000_0000_0000;
        for (int k = 0; k < 4; k++) begin
            check("lhu_hold", mem_valid, 1);
            check("lhu_size", mem_size, 1);
            mem_ready = (k == 3);
            @(negedge clk);
        end
        mem_ready = 1'b0;
        check("lhu_to_ws", ms_to_ws_valid, 1);
        check("lhu_result", ms_result, 64'h8000);
        $display("[TB] lhu pc=%h result=%h", ms_pc, ms_result);
        @(negedge clk);

        // sb into lane 5
        t0 = '0; t0.pc = 64'h10C; t0.alu = 64'h8000_0005; t0.src2 = 64'h1122_3344_5566_77AB; t0.wen = 1'b1; t0.f3 = 3'b000;
        drive(t0, 1'b1);
        @(negedge clk); es_to_ms_valid = 1'b0;
        check("sb_wen", mem_wen, 1);
        check("sb_wstrb", mem_wstrb, 8'h20);
        check("sb_lane", mem_wdata[47:40], 8'hAB);
        check("sb_size", mem_size, 0);
        mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        check("sb_result", ms_result, 64'h8000_0005);
        check("sb_reg_wen", ms_reg_wen, 0);
        $display("[TB] sb pc=%h addr=8000_0005", ms_pc);
        @(negedge clk);

        // back-to-back loads with WB stalled two cycles in DONE
        t0 = '0; t0.pc = 64'h110; t0.alu = 64'h8000_0010; t0.ren = 1'b1; t0.f3 = 3'b011; t0.reg_wen = 1'b1;
        t1 = '0; t1.pc = 64'h114; t1.alu = 64'h8000_0020; t1.ren = 1'b1; t1.f3 = 3'b011; t1.reg_wen = 1'b1;
        drive(t0, 1'b1);
        @(negedge clk); drive(t1, 1'b1); ws_allowin = 1'b0;
        mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD; mem_ready = 1'b1; #1;
        check("b2b_allowin_req", ms_allowin, 0);
        @(negedge clk); mem_ready = 1'b0; #1;
        check("b2b_hold1_to_ws", ms_to_ws_valid, 1);
        check("b2b_hold1_allowin", ms_allowin, 0);
        @(negedge clk); #1;
        check("b2b_hold2_result", ms_result, 64'hAAAA_BBBB_CCCC_DDDD);
        check("b2b_hold2_mem_valid", mem_valid, 0);
        ws_allowin = 1'b1; #1;
        check("b2b_release_allowin", ms_allowin, 1);
        @(negedge clk); es_to_ms_valid = 1'b0;
        check("b2b_second_req", mem_valid, 1);
        check("b2b_second_addr", mem_addr, 32'h8000_0020);
        mem_rdata = 64'h0123_4567_89AB_CDEF; mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        check("b2b_second_result", ms_result, 64'h0123_4567_89AB_CDEF);
        $display("[TB] b2b pc=%h result=%h", ms_pc, ms_result);
        @(negedge clk);

`ifdef MISALIGN_CHECK_EN
        t0 = '0; t0.pc = 64'h118; t0.alu = 64'h2; t0.ren = 1'b1; t0.f3 = 3'b010; t0.reg_wen = 1'b1;
        drive(t0, 1'b1);
        @(negedge clk); es_to_ms_valid = 1'b0;
        check("mis_mem_valid", mem_valid, 0);
        check("mis_excp", ms_excp, 1);
        check("mis_reg_wen", ms_reg_wen, 0);
        check("mis_to_ws", ms_to_ws_valid, 1);
        $display("[TB] misaligned lw pc=%h excp=%b", ms_pc, ms_excp);
        @(negedge clk);
`endif

        // reset while a request is outstanding
        t0 = '0; t0.pc = 64'h11C; t0.alu = 64'h8000_0040; t0.ren = 1'b1; t0.f3 = 3'b010;
        drive(t0, 1'b1);
        @(negedge clk); es_to_ms_valid = 1'b0;
        check("rstreq_pre", mem_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rstreq_mem_valid", mem_valid, 0);
        check("rstreq_to_ws", ms_to_ws_valid, 0);
        $display("[TB] reset during request");
        rst = 1'b0;

        // random traffic
        in_stage = 0; done = 0; ex_has = 0; retired = 0; cur = '0; ex_q = '0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (!ex_has && $urandom_range(0, 3) != 0) begin
                ex_q = gen_instr(); ex_has = 1;
            end
            drive(ex_q, ex_has);
            ws_allowin = ($urandom_range(0, 3) != 0);
            mem_ready  = ($urandom_range(0, 2) == 0);
            #1;
            exp_to_ws = in_stage && (!(cur.ren || cur.wen) || done);
            check("r_to_ws", ms_to_ws_valid, exp_to_ws);
            check("r_allowin", ms_allowin, !in_stage || (exp_to_ws && ws_allowin));
            check("r_isload", ms_isload, in_stage && cur.ren && !done);
            check("r_mem_valid", mem_valid, in_stage && (cur.ren || cur.wen) && !done);
            if (mem_valid) begin
                mem_rdata = mem_word(mem_addr);
                check("r_addr", mem_addr, cur.alu[31:0]);
                check("r_mwen", mem_wen, cur.wen);
                check("r_size", mem_size, cur.f3[1:0]);
                if (cur.wen) begin
                    es = strb_ref(cur.f3, cur.alu[2:0]);
                    check("r_wstrb", mem_wstrb, es);
                    got_l = '0; exp_l = '0;
                    for (int i = 0; i < 8; i++) if (es[i]) begin
                        tmp = cur.src2 >> (8 * (i - int'(cur.alu[2:0])));
                        exp_l[8*i +: 8] = tmp[7:0];
                        got_l[8*i +: 8] = mem_wdata[8*i +: 8];
                    end
                    check("r_wdata", got_l, exp_l);
                end
                if (mem_ready) done = 1;
            end
            if (ms_to_ws_valid && ws_allowin) begin
                exp_res = cur.ren ? load_ref(cur.alu[31:0], cur.f3, mem_word(cur.alu[31:0])) : cur.alu;
                check("r_pc", ms_pc, cur.pc);
                check("r_rd", ms_rd, cur.rd);
                check("r_reg_wen", ms_reg_wen, cur.reg_wen);
                check("r_result", ms_result, exp_res);
                $display("[TB] wb pc=%h rd=%0d result=%h", ms_pc, ms_rd, ms_result);
                in_stage = 0;
                retired++;
            end
            if (es_to_ms_valid && ms_allowin) begin
                cur = ex_q; in_stage = 1; done = 0; ex_has = 0;
            end
        end
        check("r_retired_enough", retired >= 100, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
